// File: rtl/traffic_pkg.sv
// Shared types and default constants for the traffic sensor conditioner.
package traffic_pkg;

  // Per-channel conditioning state.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_ON,
    S_PRESENT,
    S_HOLD
  } sensor_state_t;

  localparam int DEF_N_SYNC          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_CNT_W           = 8;

  // Larger of two ints, used to size the shared debounce/hold timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_sensor_cond_if.sv
// Signal bundle between the detector front end and its user (the light FSM side).
//
// Handshake: there is no back-pressure. car_a_pulse / car_b_pulse are
// one-cycle valid strobes with no ready; each marks a new arrival and the
// matching counter reflects it from the following cycle. TA/TB are levels.
interface traffic_sensor_cond_if
  import traffic_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             det_a_raw;
  logic             det_b_raw;
  logic             clear_counts;
  logic             TA;
  logic             TB;
  logic             car_a_pulse;
  logic             car_b_pulse;
  logic [CNT_W-1:0] car_a_cnt;
  logic [CNT_W-1:0] car_b_cnt;
  sensor_state_t    state_a;
  sensor_state_t    state_b;

  // Side that drives detectors and consumes the conditioned outputs.
  modport master (
    output det_a_raw, det_b_raw, clear_counts,
    input  TA, TB, car_a_pulse, car_b_pulse, car_a_cnt, car_b_cnt,
    input  state_a, state_b
  );

  // The conditioner itself.
  modport slave (
    input  det_a_raw, det_b_raw, clear_counts,
    output TA, TB, car_a_pulse, car_b_pulse, car_a_cnt, car_b_cnt,
    output state_a, state_b
  );
endinterface

// File: rtl/sensor_channel.sv
// One detector channel: synchroniser, debounce/hold state machine,
// arrival pulse and saturating arrival counter.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int N_SYNC          = DEF_N_SYNC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_raw,
  input  logic             clear_counts,
  output logic             t,
  output logic             pulse,
  output logic [CNT_W-1:0] cnt,
  output sensor_state_t    state
);

  localparam int TW = $clog2(max_int(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_SYNC-1:0] sync_q;
  logic [TW-1:0]     timer;
  logic              s;

  assign s = sync_q[N_SYNC-1];

  // Shift the asynchronous detector through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N_SYNC-2:0], det_raw};
    end
  end

  // Debounce on the way in, minimum hold on the way out; t and pulse are
  // registered alongside the state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      t     <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= S_PRESENT;
              timer <= '0;
              t     <= 1'b1;
              pulse <= 1'b1;
            end else begin
              state <= S_DEB_ON;
              timer <= TIMER_ONE;
            end
          end
        end
        S_DEB_ON: begin
          if (!s) begin
            state <= S_IDLE;
            timer <= '0;
          end else if (timer == DEB_LAST) begin
            state <= S_PRESENT;
            timer <= '0;
            t     <= 1'b1;
            pulse <= 1'b1;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        S_PRESENT: begin
          if (!s) begin
            if (HOLD_CYCLES == 1) begin
              state <= S_IDLE;
              timer <= '0;
              t     <= 1'b0;
            end else begin
              state <= S_HOLD;
              timer <= TIMER_ONE;
            end
          end
        end
        S_HOLD: begin
          if (s) begin
            // Retrigger: presence never dropped, so no new arrival.
            state <= S_PRESENT;
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state <= S_IDLE;
            timer <= '0;
            t     <= 1'b0;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          t     <= 1'b0;
        end
      endcase
    end
  end

  // Count arrivals; clear wins over a coincident pulse, count saturates.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      cnt <= '0;
    end else if (pulse && (cnt != CNT_MAX)) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/traffic_sensor_cond.sv
// Traffic sensor conditioner: two independent detector channels (A, B)
// producing TA/TB for the traffic light FSM. Wiring only.
module traffic_sensor_cond
  import traffic_pkg::*;
#(
  parameter int N_SYNC          = DEF_N_SYNC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  reset,
  traffic_sensor_cond_if.slave bus
);

  sensor_channel #(
    .N_SYNC         (N_SYNC),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk         (clk),
    .reset       (reset),
    .det_raw     (bus.det_a_raw),
    .clear_counts(bus.clear_counts),
    .t           (bus.TA),
    .pulse       (bus.car_a_pulse),
    .cnt         (bus.car_a_cnt),
    .state       (bus.state_a)
  );

  sensor_channel #(
    .N_SYNC         (N_SYNC),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk         (clk),
    .reset       (reset),
    .det_raw     (bus.det_b_raw),
    .clear_counts(bus.clear_counts),
    .t           (bus.TB),
    .pulse       (bus.car_b_pulse),
    .cnt         (bus.car_b_cnt),
    .state       (bus.state_b)
  );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Bench for traffic_sensor_cond: default build plus a CNT_W=2 build fed
// the same detector stimulus, checked cycle by cycle against a run-length
// presence model, with directed timing checks on top.
module tb_traffic_sensor_cond;

  localparam int N_SYNC = 2;
  localparam int DEB    = 4;
  localparam int HOLD   = 8;
  localparam int W      = 24;

  logic clk = 1'b0;
  logic reset;

  traffic_sensor_cond_if #(.CNT_W(8)) bus ();
  traffic_sensor_cond_if #(.CNT_W(2)) bus2 ();

  assign bus2.det_a_raw    = bus.det_a_raw;
  assign bus2.det_b_raw    = bus.det_b_raw;
  assign bus2.clear_counts = bus.clear_counts;

  traffic_sensor_cond #(
    .N_SYNC(N_SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  traffic_sensor_cond #(
    .N_SYNC(N_SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(2)
  ) dut_sat (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Presence rises after DEB consecutive high synced samples and falls after
  // HOLD consecutive low ones; synced value is the raw input N_SYNC edges late.
  logic [N_SYNC-1:0] sync_m[2];
  int  run_hi[2];
  int  run_lo[2];
  bit  t_m[2];
  bit  pulse_m[2];
  int  cnt8_m[2];
  int  cnt2_m[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      sync_m[c] = '0; run_hi[c] = 0; run_lo[c] = 0;
      t_m[c] = 0; pulse_m[c] = 0; cnt8_m[c] = 0; cnt2_m[c] = 0;
    end
  end

  always @(posedge clk) begin
    logic raw[2];
    logic s;
    bit   new_t;
    raw[0] = bus.det_a_raw;
    raw[1] = bus.det_b_raw;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        sync_m[c] = '0; run_hi[c] = 0; run_lo[c] = 0;
        t_m[c] = 0; pulse_m[c] = 0; cnt8_m[c] = 0; cnt2_m[c] = 0;
      end else begin
        s = sync_m[c][N_SYNC-1];
        sync_m[c] = {sync_m[c][N_SYNC-2:0], raw[c]};
        if (bus.clear_counts) begin
          cnt8_m[c] = 0;
          cnt2_m[c] = 0;
        end else if (pulse_m[c]) begin
          cnt8_m[c] = (cnt8_m[c] < 255) ? cnt8_m[c] + 1 : 255;
          cnt2_m[c] = (cnt2_m[c] < 3) ? cnt2_m[c] + 1 : 3;
        end
        if (s) begin
          run_hi[c] = (run_hi[c] < 1000) ? run_hi[c] + 1 : 1000;
          run_lo[c] = 0;
        end else begin
          run_lo[c] = (run_lo[c] < 1000) ? run_lo[c] + 1 : 1000;
          run_hi[c] = 0;
        end
        new_t = t_m[c];
        if (!t_m[c] && run_hi[c] >= DEB) new_t = 1'b1;
        else if (t_m[c] && run_lo[c] >= HOLD) new_t = 1'b0;
        pulse_m[c] = new_t && !t_m[c];
        t_m[c]     = new_t;
      end
    end
    exp_q.push_back({t_m[0], t_m[1], pulse_m[0], pulse_m[1],
                     8'(cnt8_m[0]), 8'(cnt8_m[1]),
                     2'(cnt2_m[0]), 2'(cnt2_m[1])});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {bus.TA, bus.TB, bus.car_a_pulse, bus.car_b_pulse,
               bus.car_a_cnt, bus.car_b_cnt, bus2.car_a_cnt, bus2.car_b_cnt};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t got=%h exp=%h (TA,TB,pa,pb,cnta,cntb,cnta2,cntb2) state_a=%0d state_b=%0d",
                 $time, got_v, exp_v, bus.state_a, bus.state_b);
      end
    end
  end

  // ---------------- directed check helper ----------------
  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int sat_exp[5];
    int len_a;
    int len_b;
    sat_exp = '{1, 2, 3, 3, 3};

    // 1: reset with both detectors high; everything stays 0.
    reset = 1'b1;
    bus.det_a_raw = 1'b1;
    bus.det_b_raw = 1'b1;
    bus.clear_counts = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      check("reset_TA", int'(bus.TA), 0);
      check("reset_TB", int'(bus.TB), 0);
      check("reset_cnt_a", int'(bus.car_a_cnt), 0);
    end
    reset = 1'b0;
    bus.det_a_raw = 1'b0;
    bus.det_b_raw = 1'b0;
    idle_cycles(4);

    // 2: A rises and holds; TA on edge 6, single pulse, count 1.
    bus.det_a_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check("rise_TA", int'(bus.TA), (e >= 6) ? 1 : 0);
      check("rise_pulse_a", int'(bus.car_a_pulse), (e == 6) ? 1 : 0);
      check("rise_TB", int'(bus.TB), 0);
    end
    check("rise_cnt_a", int'(bus.car_a_cnt), 1);

    // 3: B glitch of 3 cycles never raises TB.
    bus.det_b_raw = 1'b1;
    idle_cycles(3);
    bus.det_b_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      check("glitch_TB", int'(bus.TB), 0);
    end
    check("glitch_cnt_b", int'(bus.car_b_cnt), 0);

    // 4: short A low keeps TA; then held low drops TA on edge 10.
    bus.det_a_raw = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      check("hold_TA", int'(bus.TA), 1);
    end
    bus.det_a_raw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      check("retrig_TA", int'(bus.TA), 1);
      check("retrig_pulse_a", int'(bus.car_a_pulse), 0);
    end
    bus.det_a_raw = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      check("fall_TA", int'(bus.TA), (e < 10) ? 1 : 0);
    end
    idle_cycles(2);

    // 5: clear, then five clean arrivals; 2-bit counter saturates at 3.
    bus.clear_counts = 1'b1;
    @(negedge clk);
    bus.clear_counts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.det_a_raw = 1'b1;
      idle_cycles(7);
      check("sat_cnt_a2", int'(bus2.car_a_cnt), sat_exp[i]);
      check("arr_cnt_a", int'(bus.car_a_cnt), i + 1);
      bus.det_a_raw = 1'b0;
      idle_cycles(12);
    end
    // Clear coincident with an arrival pulse: that arrival is not counted.
    bus.det_a_raw = 1'b1;
    idle_cycles(6);
    check("clr_pulse_a", int'(bus.car_a_pulse), 1);
    bus.clear_counts = 1'b1;
    @(negedge clk);
    bus.clear_counts = 1'b0;
    check("clr_cnt_a", int'(bus.car_a_cnt), 0);
    check("clr_cnt_a2", int'(bus2.car_a_cnt), 0);
    @(negedge clk);
    check("clr_cnt_a_after", int'(bus.car_a_cnt), 0);
    bus.det_a_raw = 1'b0;
    idle_cycles(12);

    // 6: reset during B hold; TB drops next cycle, full debounce afterwards.
    bus.det_b_raw = 1'b1;
    idle_cycles(8);
    bus.det_b_raw = 1'b0;
    idle_cycles(4);
    check("hold_TB", int'(bus.TB), 1);
    reset = 1'b1;
    bus.det_b_raw = 1'b1;
    @(negedge clk);
    check("rst_hold_TB", int'(bus.TB), 0);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      check("post_rst_TB", int'(bus.TB), (e >= 6) ? 1 : 0);
    end
    bus.det_b_raw = 1'b0;
    idle_cycles(12);

    // 7: random detector activity, occasional clears and resets.
    len_a = 0;
    len_b = 0;
    for (int i = 0; i < 800; i++) begin
      if (len_a == 0) begin
        bus.det_a_raw = 1'($urandom_range(0, 1));
        len_a = $urandom_range(1, 12);
      end
      if (len_b == 0) begin
        bus.det_b_raw = 1'($urandom_range(0, 1));
        len_b = $urandom_range(1, 12);
      end
      bus.clear_counts = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      len_a--;
      len_b--;
    end
    reset = 1'b0;
    bus.clear_counts = 1'b0;
    idle_cycles(3);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
